// File: rtl/ra_2r1w_32x32_arb.sv
// ra_2r1w_32x32_arb
// Round-robin front end for a 2-read / 1-write 32x32 register-file wrapper.
// Up to two reads and one write from four requesters are packed onto the
// array ports each cycle. Reads that would race a recent write to the same
// address are held back. Read data is routed back to the requester that
// issued the read once the wrapper's fixed read latency has elapsed.
module ra_2r1w_32x32_arb #(
   parameter int NREQ   = 4,
   parameter int RD_LAT = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ-1:0]      req_we,
   input  logic [5*NREQ-1:0]    req_adr,
   input  logic [32*NREQ-1:0]   req_wdat,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [32*NREQ-1:0]   rsp_dat,
   output logic                 ra_rd_enb_0,
   output logic                 ra_rd_enb_1,
   output logic [4:0]           ra_rd_adr_0,
   output logic [4:0]           ra_rd_adr_1,
   input  logic [31:0]          ra_rd_dat_0,
   input  logic [31:0]          ra_rd_dat_1,
   output logic                 ra_wr_enb_0,
   output logic [4:0]           ra_wr_adr_0,
   output logic [31:0]          ra_wr_dat_0,
   output logic                 busy
);

   logic [1:0]        rr_ptr;
   logic [1:0]        nxt_ptr;
   logic              hz_vld;
   logic [4:0]        hz_adr;

   logic [4:0]        adr_of   [NREQ];
   logic [31:0]       wdat_of  [NREQ];
   logic [1:0]        scan_idx [NREQ];

   logic              wr_gnt;
   logic [1:0]        wr_id;
   logic              rd_gnt_0;
   logic              rd_gnt_1;
   logic [1:0]        rd_id_0;
   logic [1:0]        rd_id_1;
   logic [NREQ-1:0]   grant;

   logic [1:0]        rd_tag_0;
   logic [1:0]        rd_tag_1;
   logic [RD_LAT-1:0] pipe_vld_0;
   logic [RD_LAT-1:0] pipe_vld_1;
   logic [1:0]        pipe_id_0 [RD_LAT];
   logic [1:0]        pipe_id_1 [RD_LAT];
   logic [NREQ-1:0]   rsp_vld_nxt;

   // Split the flat request buses per requester and build the rotated scan order
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         adr_of[i]   = req_adr[5*i +: 5];
         wdat_of[i]  = req_wdat[32*i +: 32];
         scan_idx[i] = rr_ptr + 2'(i);
      end
   end

   // Pick the first write in scan order, then the first two reads that do not collide with it or last cycle's write
   always_comb begin
      wr_gnt   = 1'b0;
      wr_id    = 2'd0;
      rd_gnt_0 = 1'b0;
      rd_gnt_1 = 1'b0;
      rd_id_0  = 2'd0;
      rd_id_1  = 2'd0;
      grant    = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!wr_gnt && req_valid[scan_idx[k]] && req_we[scan_idx[k]]) begin
            wr_gnt = 1'b1;
            wr_id  = scan_idx[k];
         end
      end
      for (int k = 0; k < NREQ; k++) begin
         if (req_valid[scan_idx[k]] && !req_we[scan_idx[k]] &&
             !(wr_gnt && (adr_of[scan_idx[k]] == adr_of[wr_id])) &&
             !(hz_vld && (adr_of[scan_idx[k]] == hz_adr))) begin
            if (!rd_gnt_0) begin
               rd_gnt_0 = 1'b1;
               rd_id_0  = scan_idx[k];
            end else if (!rd_gnt_1) begin
               rd_gnt_1 = 1'b1;
               rd_id_1  = scan_idx[k];
            end
         end
      end
      if (wr_gnt)   grant[wr_id]   = 1'b1;
      if (rd_gnt_0) grant[rd_id_0] = 1'b1;
      if (rd_gnt_1) grant[rd_id_1] = 1'b1;
   end

   // Next pointer starts just past the last granted requester in scan order so every requester gets its turn
   always_comb begin
      nxt_ptr = rr_ptr;
      for (int k = 0; k < NREQ; k++) begin
         if (grant[scan_idx[k]]) nxt_ptr = scan_idx[k] + 2'd1;
      end
   end

   assign req_ready = grant;

   // Register the winning accesses onto the array pins and remember this cycle's write address for the hazard check
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr      <= 2'd0;
         hz_vld      <= 1'b0;
         hz_adr      <= 5'd0;
         ra_rd_enb_0 <= 1'b0;
         ra_rd_enb_1 <= 1'b0;
         ra_rd_adr_0 <= 5'd0;
         ra_rd_adr_1 <= 5'd0;
         rd_tag_0    <= 2'd0;
         rd_tag_1    <= 2'd0;
         ra_wr_enb_0 <= 1'b0;
         ra_wr_adr_0 <= 5'd0;
         ra_wr_dat_0 <= 32'd0;
      end else begin
         rr_ptr      <= nxt_ptr;
         hz_vld      <= wr_gnt;
         hz_adr      <= adr_of[wr_id];
         ra_rd_enb_0 <= rd_gnt_0;
         ra_rd_enb_1 <= rd_gnt_1;
         ra_wr_enb_0 <= wr_gnt;
         if (rd_gnt_0) begin
            ra_rd_adr_0 <= adr_of[rd_id_0];
            rd_tag_0    <= rd_id_0;
         end
         if (rd_gnt_1) begin
            ra_rd_adr_1 <= adr_of[rd_id_1];
            rd_tag_1    <= rd_id_1;
         end
         if (wr_gnt) begin
            ra_wr_adr_0 <= adr_of[wr_id];
            ra_wr_dat_0 <= wdat_of[wr_id];
         end
      end
   end

   // Carry each issued read's owner alongside the array's read latency
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_vld_0 <= '0;
         pipe_vld_1 <= '0;
         for (int j = 0; j < RD_LAT; j++) begin
            pipe_id_0[j] <= 2'd0;
            pipe_id_1[j] <= 2'd0;
         end
      end else begin
         pipe_vld_0[0] <= ra_rd_enb_0;
         pipe_vld_1[0] <= ra_rd_enb_1;
         pipe_id_0[0]  <= rd_tag_0;
         pipe_id_1[0]  <= rd_tag_1;
         for (int j = 1; j < RD_LAT; j++) begin
            pipe_vld_0[j] <= pipe_vld_0[j-1];
            pipe_vld_1[j] <= pipe_vld_1[j-1];
            pipe_id_0[j]  <= pipe_id_0[j-1];
            pipe_id_1[j]  <= pipe_id_1[j-1];
         end
      end
   end

   // Decode which requesters receive data this cycle from the pipe tails
   always_comb begin
      rsp_vld_nxt = '0;
      if (pipe_vld_0[RD_LAT-1]) rsp_vld_nxt[pipe_id_0[RD_LAT-1]] = 1'b1;
      if (pipe_vld_1[RD_LAT-1]) rsp_vld_nxt[pipe_id_1[RD_LAT-1]] = 1'b1;
   end

   // Capture returning array data into the owning requester's slot; other slots keep their last value
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid <= '0;
         rsp_dat   <= '0;
      end else begin
         rsp_valid <= rsp_vld_nxt;
         for (int i = 0; i < NREQ; i++) begin
            if (pipe_vld_0[RD_LAT-1] && (pipe_id_0[RD_LAT-1] == 2'(i)))
               rsp_dat[32*i +: 32] <= ra_rd_dat_0;
            else if (pipe_vld_1[RD_LAT-1] && (pipe_id_1[RD_LAT-1] == 2'(i)))
               rsp_dat[32*i +: 32] <= ra_rd_dat_1;
         end
      end
   end

   assign busy = (|pipe_vld_0) | (|pipe_vld_1) | ra_rd_enb_0 | ra_rd_enb_1 | ra_wr_enb_0;

endmodule

// File: doc/ra_2r1w_32x32_arb.md
Name: ra_2r1w_32x32_arb

Overview:
Shares one 2r1w 32x32 register-file wrapper (two read ports, one write port, 5-bit address, 32-bit data) between NREQ independent requesters. Each cycle a round-robin scheduler packs up to two reads and one write onto the array ports and blocks read-after-write hazards. It tracks in-flight reads through the wrapper's fixed read latency and returns each read's data to the requester that issued it. The block sits directly in front of the array wrapper; its ra_* outputs drive the wrapper's input pins.

Parameters:
NREQ, 4, number of requesters; fixed at 4 for this revision (2-bit pointer).
RD_LAT, 2, cycles from ra_rd_enb_x asserted to valid ra_rd_dat_x. Use 2 when the wrapper latches read data, 1 when it does not.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  4  request valid, bit i = requester i
req_ready  out  4  request accepted this cycle (grant)
req_we  in  4  1 = write, 0 = read
req_adr  in  20  address; requester i uses bits [5i+4:5i]
req_wdat  in  128  write data; requester i uses bits [32i+31:32i]
rsp_valid  out  4  read data valid for requester i
rsp_dat  out  128  read data; requester i uses bits [32i+31:32i]
ra_rd_enb_0, ra_rd_enb_1  out  1 each  array read enables
ra_rd_adr_0, ra_rd_adr_1  out  5 each  array read addresses
ra_rd_dat_0, ra_rd_dat_1  in  32 each  array read data
ra_wr_enb_0  out  1  array write enable
ra_wr_adr_0  out  5  array write address
ra_wr_dat_0  out  32  array write data
busy  out  1  any read in flight or any ra_*_enb asserted

Behaviour:
- Reset: asynchronous on reset_n low. All state clears: rr_ptr=0, in-flight pipes, hazard register, rsp_valid, rsp_dat, every ra_* output and busy all go to 0. In-flight reads are discarded and produce no rsp_valid after reset releases.
- Arbitration (combinational in cycle T):
  - Scan order is rr_ptr, rr_ptr+1, ... mod 4.
  - The first eligible read in scan order gets read port 0; the second gets read port 1.
  - The first write in scan order gets the write port.
  - A requester whose port type is already exhausted stays ungranted and holds its request.
- req_ready[i] = 1 in cycle T exactly when requester i is granted. A transfer occurs on valid && ready. req_ready never asserts without req_valid.
- Requesters must hold valid, we, adr and wdat stable until ready.
- Hazard: a read is ineligible in cycle T if its address equals the address of a write granted in T, or of the write granted in T-1 (hz_vld/hz_adr register). It retries in the next cycle. A write is never blocked by a read.
- rr_ptr update: if any grant in T, rr_ptr <= (highest-scan-position granted index + 1) mod 4. Otherwise rr_ptr holds.
- Array outputs are registered. A grant in T drives ra_rd_enb_x, ra_rd_adr_x, ra_wr_enb_0, ra_wr_adr_0 and ra_wr_dat_0 in T+1. When a port is not granted, its enb=0 and its adr/dat hold their previous values.
- Read tracking: each read port has an RD_LAT-deep shift register of {valid, 2-bit requester id}, loaded in T+1.
  - In cycle T+1+RD_LAT, ra_rd_dat_x is captured into rsp_dat for that id.
  - rsp_valid[id] pulses for one cycle at T+2+RD_LAT. With the default RD_LAT=2, that is T+4.
- Both ports can return in the same cycle only for distinct requesters; no collision logic is needed.
- rsp_dat[i] holds its last value when rsp_valid[i]=0.
- Throughput: 2 reads + 1 write per cycle, sustained. A lone requester may be granted every cycle.
- busy = OR of all pipe valid bits and all registered enbs.

Test Plan:
- Reset/idle: assert reset_n=0 mid-stream with 2 reads in flight, release -> all outputs 0, no rsp_valid ever appears for the dropped reads, rr_ptr=0.
- Single write then read: req0 writes adr 5 data 0xDEADBEEF at T0. req1 reads adr 5 at T0 -> read blocked at T0 and T1, granted at T2, rsp_valid[1] at T6 with 0xDEADBEEF (RD_LAT=2).
- Full packing: all four requesters issue reads at T0 with rr_ptr=0 -> ready=0011. Port 0 adr from req0, port 1 from req1. rr_ptr=2. The next cycle grants req2 and req3.
- Mixed: req0 write, req1/req2/req3 reads to distinct addresses, rr_ptr=1 -> grants req1 and req2 reads plus req0 write (ready=0111). rr_ptr=1, since req0 is the highest scan position granted.
- Fairness: all four requesters hold write requests continuously for 8 cycles -> grants rotate 0,1,2,3,0,1,2,3; each requester gets exactly 2.
- Latency check with RD_LAT=1: a read granted at T gives rsp_valid at T+3 with the array data sampled at T+2.
